imm_ext_pipe: RTL
=================

Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the decode stage. Generalises the fixed 17-bit and 27-bit sign extenders.
- Per transaction it selects a runtime field width and one of four extension modes. Modes cover zero and sign extension, each with an optional fixed left shift for branch and jump targets.
- Results are buffered in a small output FIFO with valid/ready handshakes on both sides, so decode back-pressure does not stall fetch.

Parameters:
- IN_W, 27: width of raw immediate input; legal 1..32.
- OUT_W, 32: width of extended output; must be >= IN_W.
- FW_W, 5: width of field-width select; must satisfy 2^FW_W > IN_W.
- SHL, 2: fixed left-shift amount applied in shifted modes; legal 0..4.
- DEPTH, 2: output FIFO entries; legal 1..8.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a transaction.
- in_ready  out  1  unit can accept a transaction this cycle.
- in_data  in  IN_W  raw immediate bits; LSB-aligned.
- in_fld_w  in  FW_W  number of valid LSBs in in_data.
- in_mode  in  2  extension mode: 00 ZERO, 01 SIGN, 10 SIGN_SHL, 11 ZERO_SHL.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  OUT_W  extended result at FIFO head.
- out_err  out  1  non-canonical input flag; present only with the optional feature.

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - FIFO count = 0, read and write pointers = 0.
  - out_valid = 0, in_ready = 1 (one cycle after reset is sampled).
  - out_data = 0, out_err = 0.
- Accept and release:
  - Accept occurs when in_valid && in_ready on a clock edge.
  - Release occurs when out_valid && out_ready.
- Field width:
  - Effective width fw = min(in_fld_w, IN_W).
  - fw = 0 produces 0 in every mode.
- Extension:
  - Bits above fw-1 of in_data are ignored.
  - ZERO: upper bits are 0.
  - SIGN: upper bits = in_data[fw-1].
- Shifted modes (SIGN_SHL, ZERO_SHL): the extended value is shifted left by SHL. Vacated LSBs are 0 and the result is truncated to OUT_W.
- Latency: 1 cycle. A result accepted at edge N is visible at out_data with out_valid = 1 after edge N when the FIFO was empty.
- Ordering: FIFO order is strict; no reordering.
- in_ready:
  - in_ready = (count != DEPTH). It is a registered function of count only and never depends combinationally on out_ready.
  - When full, a same-cycle pop does not allow a push. in_ready rises the cycle after the pop.
- Simultaneous push and pop when not full or empty: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Stable head: out_data and out_err stay stable while out_valid && !out_ready.
- Pop on empty is ignored: out_ready with out_valid = 0 has no effect.
- Reset mid-operation: all buffered entries are discarded. out_valid falls and in_ready rises after the reset edge. A transaction presented during reset is not accepted.

Optional Feature:
- Macro: IMM_EXT_CANON_CHECK_EN.
- With the macro defined:
  - The out_err port exists.
  - For each entry it is set when any in_data bit at index >= fw is nonzero.
  - It is stored in the FIFO alongside the data and reset to 0.
- Without the macro: the out_err port is absent, there is no extra storage, and extension behaviour is identical.

Decomposition:
- Package imm_ext_pkg:
  - Mode encoding as a 2-bit typedef with constants MODE_ZERO, MODE_SIGN, MODE_SIGN_SHL, MODE_ZERO_SHL.
  - The entry struct (data plus optional err).
- One sub-module imm_ext_core:
  - Purely combinational: in_data, fw and mode in; extended value (and err) out.
  - imm_ext_pipe instantiates it and owns the FIFO, pointers, count and handshake logic.

Test Plan:
- Sign 17-bit: IN_W = 27, OUT_W = 32. in_data = 0x0010000, fld_w = 17, mode SIGN -> out_data = 0xFFFF0000 one cycle later. Same input with mode ZERO -> 0x00010000.
- Sign 27-bit plus shift: in_data = 0x4000000, fld_w = 27, mode SIGN -> 0xFC000000. in_data = 0x0008000, fld_w = 16, mode SIGN_SHL (SHL = 2) -> 0xFFFE0000.
- Width edges: fld_w = 0 with any data -> 0. fld_w = 31 (> IN_W) is clamped to 27. in_data = 0x7FFFFFF, mode ZERO_SHL -> 0x1FFFFFFC.
- Back-pressure (DEPTH = 2): hold out_ready = 0 and push 3 back-to-back -> in_ready low after 2 accepts, third held. Release one pop -> in_ready high the next cycle, order preserved.
- Reset mid-operation: with 2 entries buffered, assert reset for 1 cycle -> out_valid = 0, in_ready = 1, old entries never appear. With the feature defined, out_err = 0.
- Feature (IMM_EXT_CANON_CHECK_EN): in_data = 0x0030000, fld_w = 17 -> out_data = 0xFFFF0000, out_err = 1. in_data = 0x0010000 -> out_err = 0.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared types for the immediate-extension pipe (optional IMM_EXT_CANON_CHECK_EN)
package imm_ext_pkg;

    // Widest OUT_W supported; FIFO entries carry this many data bits.
    localparam int IMM_EXT_MAX_W = 64;

    typedef enum logic [1:0] {
        MODE_ZERO     = 2'b00,
        MODE_SIGN     = 2'b01,
        MODE_SIGN_SHL = 2'b10,
        MODE_ZERO_SHL = 2'b11
    } mode_t;

    typedef struct packed {
        logic [IMM_EXT_MAX_W-1:0] data;
`ifdef IMM_EXT_CANON_CHECK_EN
        logic                     err;
`endif
    } entry_t;

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational zero/sign extension with optional shift (optional IMM_EXT_CANON_CHECK_EN)
module imm_ext_core #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 32,
    parameter int FW_W  = 5,
    parameter int SHL   = 2
) (
    input  logic [IN_W-1:0]  data,
    input  logic [FW_W-1:0]  fw,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
`ifdef IMM_EXT_CANON_CHECK_EN
    ,
    output logic             err
`endif
);
    import imm_ext_pkg::*;

    mode_t            m;
    logic [IN_W-1:0]  keep;
    logic             sign_bit;
    logic             fill;
    logic [OUT_W-1:0] base;

    // fw is already clamped to IN_W, so fw = 0 leaves keep empty and sign_bit 0.
    always_comb begin
        m        = mode_t'(mode);
        keep     = '0;
        sign_bit = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (i < int'(fw)) keep[i] = 1'b1;
            if (i + 1 == int'(fw)) sign_bit = data[i];
        end
        fill = (m == MODE_SIGN || m == MODE_SIGN_SHL) ? sign_bit : 1'b0;
        base = {OUT_W{fill}};
        for (int i = 0; i < IN_W; i++) begin
            if (keep[i]) base[i] = data[i];
        end
        ext = (m == MODE_SIGN_SHL || m == MODE_ZERO_SHL) ? (base << SHL) : base;
    end

`ifdef IMM_EXT_CANON_CHECK_EN
    assign err = |(data & ~keep);
`endif

endmodule

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - pipelined immediate extender with output FIFO (optional IMM_EXT_CANON_CHECK_EN)
module imm_ext_pipe #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 32,
    parameter int FW_W  = 5,
    parameter int SHL   = 2,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [FW_W-1:0]  in_fld_w,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_CANON_CHECK_EN
    ,
    output logic             out_err
`endif
);
    import imm_ext_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [FW_W-1:0]  fw;
    logic [OUT_W-1:0] ext_data;
    logic             push;
    logic             pop;
`ifdef IMM_EXT_CANON_CHECK_EN
    logic             ext_err;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fw = (int'(in_fld_w) > IN_W) ? FW_W'(IN_W) : in_fld_w;

    imm_ext_core #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .FW_W (FW_W),
        .SHL  (SHL)
    ) u_core (
        .data(in_data),
        .fw  (fw),
        .mode(in_mode),
        .ext (ext_data)
`ifdef IMM_EXT_CANON_CHECK_EN
        ,
        .err (ext_err)
`endif
    );

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = IMM_EXT_MAX_W'(ext_data);
`ifdef IMM_EXT_CANON_CHECK_EN
        wr_entry.err  = ext_err;
`endif
    end

    // in_ready is registered, so a pop on a full FIFO cannot admit a push in the same cycle.
    assign push = in_valid && in_ready && !reset;
    assign pop  = out_valid && out_ready && !reset;

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (!push && pop) count_next = count - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_ready <= 1'b1;
        end else begin
            count    <= count_next;
            in_ready <= (count_next != CNT_W'(DEPTH));
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? OUT_W'(head.data) : '0;
`ifdef IMM_EXT_CANON_CHECK_EN
    assign out_err   = out_valid ? head.err : 1'b0;
`endif

endmodule
